// File: rtl/tinyqv_register_file_pkg.sv
// Shared constants for the tinyQV RV32E integer register file.
package tinyqv_register_file_pkg;

  localparam int unsigned REG_ADDR_BITS = 4;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned NUM_REGS      = 16;

  localparam logic [REG_ADDR_BITS-1:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/tinyqv_reg_word.sv
// Single register word with asynchronous active-low clear and write enable.
module tinyqv_reg_word #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
    end else if (wr_en_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/tinyqv_register_file.sv
// tinyQV integer register file: x0 hardwired to zero, two combinational reads, one write.
module tinyqv_register_file
  import tinyqv_register_file_pkg::*;
#(
  parameter int unsigned REG_ADDR_BITS = tinyqv_register_file_pkg::REG_ADDR_BITS,
  parameter int unsigned XLEN          = tinyqv_register_file_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [REG_ADDR_BITS-1:0] rs1,
  input  logic [REG_ADDR_BITS-1:0] rs2,
  input  logic [REG_ADDR_BITS-1:0] rd,
  output logic [XLEN-1:0]          rs1_out,
  output logic [XLEN-1:0]          rs2_out,
  input  logic [XLEN-1:0]          rd_in
);

  localparam int unsigned NumRegs = 1 << REG_ADDR_BITS;

  logic [NumRegs-1:0] reg_we;
  logic [XLEN-1:0]    regs [NumRegs];

  // One-hot write decode; writes to x0 are dropped here so x0 needs no storage.
  always_comb begin
    reg_we = '0;
    if (wr_en && (rd != REG_ZERO)) begin
      reg_we[rd] = 1'b1;
    end
  end

  assign regs[0] = '0;

  for (genvar i = 1; i < NumRegs; i++) begin : g_regs
    tinyqv_reg_word #(
      .Width (XLEN)
    ) u_word (
      .clk_i   (clk),
      .rst_ni  (rstn),
      .wr_en_i (reg_we[i]),
      .d_i     (rd_in),
      .q_o     (regs[i])
    );
  end

  // No write bypass: a read of rd in the write cycle returns the old value.
  assign rs1_out = (rs1 == REG_ZERO) ? '0 : regs[rs1];
  assign rs2_out = (rs2 == REG_ZERO) ? '0 : regs[rs2];

endmodule

// File: tb/tb_tinyqv_register_file.sv
// Directed, table-driven bench for tinyqv_register_file.
module tb_tinyqv_register_file;

  logic        clk;
  logic        rstn;
  logic        wr_en;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic [31:0] rs1_out;
  logic [31:0] rs2_out;
  logic [31:0] rd_in;

  int total;
  int bad;

  typedef struct {
    logic        wr_en;
    logic [3:0]  rd;
    logic [31:0] rd_in;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    string       name;
  } vec_t;

  vec_t vecs[$];

  tinyqv_register_file dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .rs1_out (rs1_out),
    .rs2_out (rs2_out),
    .rd_in   (rd_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic w, input logic [3:0] d, input logic [31:0] din,
                     input logic [3:0] a, input logic [3:0] b,
                     input logic [31:0] e1, input logic [31:0] e2, input string name);
    vec_t v;
    v.wr_en = w; v.rd = d; v.rd_in = din; v.rs1 = a; v.rs2 = b;
    v.exp1 = e1; v.exp2 = e2; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    wr_en = 1'b0;
    rs1   = '0;
    rs2   = '0;
    rd    = '0;
    rd_in = '0;

    // Expected values are the pre-edge reads in each vector's cycle (old contents).
    for (int i = 1; i < 16; i++) begin
      add(1'b1, 4'(i), 32'h1000_0000 + i, 4'(i), 4'd0, 32'h0, 32'h0, "wr_old");
    end
    add(1'b1, 4'd0, 32'hDEAD_BEEF, 4'd1, 4'd1, 32'h1000_0001, 32'h1000_0001, "wr_x0");
    add(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 32'h0, 32'h0, "x0_zero");
    for (int i = 1; i < 16; i++) begin
      add(1'b0, 4'd0, 32'h0, 4'(i), 4'(16 - i), 32'h1000_0000 + i,
          32'h1000_0000 + (16 - i), "sweep");
    end
    add(1'b1, 4'd5, 32'h1234_5678, 4'd5, 4'd4, 32'h1000_0005, 32'h1000_0004, "wr_x5");
    for (int k = 0; k < 3; k++) begin
      add(1'b0, 4'd5, 32'hFFFF_FFFF, 4'd5, 4'd5, 32'h1234_5678, 32'h1234_5678, "wr_dis");
    end
    add(1'b0, 4'd5, 32'hFFFF_FFFF, 4'd6, 4'd5, 32'h1000_0006, 32'h1234_5678, "wr_dis_after");
    add(1'b1, 4'd3, 32'hAAAA_5555, 4'd3, 4'd2, 32'h1000_0003, 32'h1000_0002, "wr_x3");
    add(1'b1, 4'd3, 32'h0F0F_0F0F, 4'd3, 4'd3, 32'hAAAA_5555, 32'hAAAA_5555, "rdw_old");
    add(1'b0, 4'd3, 32'h0, 4'd3, 4'd3, 32'h0F0F_0F0F, 32'h0F0F_0F0F, "rdw_new");

    // Reset held with a write attempted: all reads stay zero.
    wr_en = 1'b1;
    rd    = 4'd1;
    rd_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rs1 = 4'(i);
      rs2 = 4'(15 - i);
      #1;
      check("reset_rs1", rs1_out, 32'h0);
      check("reset_rs2", rs2_out, 32'h0);
    end
    wr_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[n]) begin
      @(negedge clk);
      wr_en = vecs[n].wr_en;
      rd    = vecs[n].rd;
      rd_in = vecs[n].rd_in;
      rs1   = vecs[n].rs1;
      rs2   = vecs[n].rs2;
      #1;
      check({vecs[n].name, "_rs1"}, rs1_out, vecs[n].exp1);
      check({vecs[n].name, "_rs2"}, rs2_out, vecs[n].exp2);
    end

    // New value visible just after the write edge.
    @(negedge clk);
    wr_en = 1'b1;
    rd    = 4'd3;
    rd_in = 32'h1111_2222;
    rs1   = 4'd3;
    rs2   = 4'd3;
    #1;
    check("edge_pre", rs1_out, 32'h0F0F_0F0F);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("edge_post_rs1", rs1_out, 32'h1111_2222);
    check("edge_post_rs2", rs2_out, 32'h1111_2222);

    // Async reset pulse between edges clears immediately.
    @(negedge clk);
    wr_en = 1'b1;
    rd    = 4'd7;
    rd_in = 32'hCAFE_F00D;
    rs1   = 4'd7;
    rs2   = 4'd5;
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("x7_loaded", rs1_out, 32'hCAFE_F00D);
    #1;
    rstn = 1'b0;
    #1;
    check("async_rst_rs1", rs1_out, 32'h0);
    check("async_rst_rs2", rs2_out, 32'h0);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("after_rst", rs1_out, 32'h0);
    wr_en = 1'b1;
    rd    = 4'd7;
    rd_in = 32'h0000_0001;
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("x7_rewrite", rs1_out, 32'h0000_0001);
    check("x5_cleared", rs2_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/tinyqv_register_file.md
Name: tinyqv_register_file

Overview:
- General-purpose integer register file for the tinyQV RV32E core: 16 architectural registers (x0..x15), each 32 bits wide.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- x0 is hardwired to zero.
- Sits between the decoder/issue logic and the ALU; instruction operands are read here and results are written back here.

Parameters:
- REG_ADDR_BITS, 4, register index width; 16 registers.
- XLEN, 32, register data width.
- Only the defaults are required to work; other values are not supported.

Ports:
- clk  input  1  rising-edge clock for all writes.
- rstn  input  1  asynchronous active-low reset.
- wr_en  input  1  write enable for port rd; sampled at the rising clk edge.
- rs1  input  4  read port 1 register index.
- rs2  input  4  read port 2 register index.
- rd  input  4  write port register index.
- rs1_out  output  32  contents of register rs1.
- rs2_out  output  32  contents of register rs2.
- rd_in  input  32  data written to register rd.

Behaviour:
- Storage: x1..x15, 15 x 32-bit flops. x0 has no storage.
- Reset: when rstn goes low, all of x1..x15 clear to 0 immediately, without waiting for a clock edge. While rstn is low, both read ports output 0 and writes are ignored. After rstn deasserts, the first write takes effect at the next rising clk edge.
- Write: on a rising clk edge with rstn=1, wr_en=1 and rd!=0, register[rd] <= rd_in.
  - wr_en=0 leaves all registers unchanged.
  - rd=0 discards the write.
- Read: rs1_out = (rs1==0) ? 0 : register[rs1], and likewise for rs2_out. Reads are purely combinational with zero-cycle latency.
  - rs1 and rs2 may equal each other and/or rd.
- Read-during-write: there is no bypass. When rs1 or rs2 equals rd in the write cycle, the port returns the old value until the clock edge. The new value appears combinationally just after the edge.
- Rd index width: all 4 bits are decoded. Every index 0..15 is valid, so there is no out-of-range case.
- No other side effects. rd_in is unconstrained when wr_en=0.

Decomposition:
- Shared package: REG_ADDR_BITS=4, XLEN=32, NUM_REGS=16, and the constant REG_ZERO=4'd0.
- One natural sub-module: tinyqv_reg_word. It is a single 32-bit register with async active-low clear and a write enable. The top instantiates it 15 times (x1..x15).
- The top-level file contains:
  - the rd one-hot write decoder, gated by wr_en and rd!=0;
  - two 16:1 read multiplexers, with entry 0 tied to zero.

Test Plan:
- Reset: hold rstn=0 with clk running, then release. Read rs1/rs2 over all indices 0..15 -> every output is 0x00000000.
- Write/read all: for i=1..15, write rd=i, rd_in=0x1000_0000+i with wr_en=1. Then sweep rs1=i and rs2=16-i -> rs1_out=0x1000_0000+i and rs2_out=0x1000_0000+(16-i).
- x0 immutable: write rd=0, rd_in=0xDEADBEEF, wr_en=1 -> rs1=0 and rs2=0 both read 0x00000000.
- Write disable: x5=0x12345678, then apply rd=5, rd_in=0xFFFFFFFF with wr_en=0 for 3 cycles -> rs1=5 still reads 0x12345678.
- Read-during-write: x3=0xAAAA5555; set rs1=rs2=rd=3, rd_in=0x0F0F0F0F, wr_en=1 -> before the edge both outputs are 0xAAAA5555; after the edge both are 0x0F0F0F0F.
- Async reset mid-operation: x7=0xCAFEF00D; pulse rstn low between clock edges -> rs1=7 reads 0 immediately, with no clock edge needed. A subsequent write of 0x1 to x7 reads back 0x00000001.
